// File: rtl/uart_tx_frame_scheduler.sv
// uart_tx_frame_scheduler: snapshots local game state and streams it to the
// UART TX core as a 14-byte frame (4 x 0xFF preamble + 10 payload bytes).
// Frames start on the periodic tick, on force_send, or on a pending request.
// Each request that arrives during a frame is merged into a single follow-up frame.
module uart_tx_frame_scheduler #(
  parameter int FRAME_PERIOD = 650000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        force_send,
  input  logic [15:0] xpos_tank_in,
  input  logic [15:0] ypos_tank_in,
  input  logic [9:0]  xpos_bullet_in,
  input  logic [9:0]  ypos_bullet_in,
  input  logic [7:0]  hp_in,
  input  logic [2:0]  direction_for_enemy_in,
  input  logic        tank_hit_in,
  input  logic [1:0]  direction_tank_in,
  input  logic        obstacle_hit_in,
  input  logic        tx_done,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        frame_done
);

  localparam int              CNT_W    = (FRAME_PERIOD > 2) ? $clog2(FRAME_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]       LAST_IDX = 4'd13;

  typedef enum logic {IDLE, WAIT_DONE} state_t;

  typedef struct packed {
    logic [15:0] xpos_tank;
    logic [15:0] ypos_tank;
    logic [9:0]  xpos_bullet;
    logic [9:0]  ypos_bullet;
    logic [7:0]  hp;
    logic [2:0]  direction_for_enemy;
    logic        tank_hit;
    logic [1:0]  direction_tank;
    logic        obstacle_hit;
  } snapshot_t;

  state_t           state, state_next;
  snapshot_t        snap;
  logic [CNT_W-1:0] period_cnt;
  logic [3:0]       idx, idx_next, idx_inc;
  logic             pending;
  logic             tick, trigger, byte_accept, frame_start;
  logic             tx_start_next, busy_next, frame_done_next;
  logic [7:0]       tx_data_next;

  // Byte layout expected by the peer's receive deframer.
  function automatic logic [7:0] frame_byte(input snapshot_t s, input logic [3:0] i);
    logic [7:0] b;
    case (i)
      4'd0, 4'd1, 4'd2, 4'd3: b = 8'hFF;
      4'd4:  b = s.xpos_tank[7:0];
      4'd5:  b = s.xpos_tank[15:8];
      4'd6:  b = s.ypos_tank[7:0];
      4'd7:  b = s.ypos_tank[15:8];
      4'd8:  b = s.xpos_bullet[7:0];
      4'd9:  b = {6'b0, s.xpos_bullet[9:8]};
      4'd10: b = s.ypos_bullet[7:0];
      4'd11: b = {6'b0, s.ypos_bullet[9:8]};
      4'd12: b = s.hp;
      4'd13: b = {1'b0, s.obstacle_hit, s.direction_tank, s.direction_for_enemy, s.tank_hit};
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // A tx_done that coincides with our own tx_start cannot belong to the byte just issued.
  assign tick        = enable && (period_cnt == CNT_LAST);
  assign trigger     = tick || (force_send && enable) || pending;
  assign byte_accept = tx_done && !tx_start;
  assign frame_start = (state == IDLE) && trigger && enable;
  assign idx_inc     = idx + 4'd1;

  // Period counter: free-runs 0..FRAME_PERIOD-1 while enabled, parked at 0 otherwise.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking (<=) so every register sees pre-edge values.
    if (!rst || !enable || period_cnt == CNT_LAST) period_cnt <= '0;
    else                                           period_cnt <= period_cnt + CNT_ONE;
  end

  // Pending request: remembers triggers seen mid-frame, coalesced into one follow-up.
  always_ff @(posedge clk) begin
    if (!rst || !enable || frame_start) pending <= 1'b0;
    else if (trigger && busy)           pending <= 1'b1;
  end

  // Payload snapshot: captured once at frame start so the frame is self-consistent.
  always_ff @(posedge clk) begin
    if (!rst) begin
      snap <= '0;
    end else if (frame_start) begin
      snap <= '{xpos_tank:           xpos_tank_in,
                ypos_tank:           ypos_tank_in,
                xpos_bullet:         xpos_bullet_in,
                ypos_bullet:         ypos_bullet_in,
                hp:                  hp_in,
                direction_for_enemy: direction_for_enemy_in,
                tank_hit:            tank_hit_in,
                direction_tank:      direction_tank_in,
                obstacle_hit:        obstacle_hit_in};
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // FSM next-state logic.
  always_comb begin
    // NOTE: default assignment first on every always_comb output, so no latch is inferred.
    state_next = state;
    case (state)
      IDLE:      if (frame_start) state_next = WAIT_DONE;
      WAIT_DONE: if (byte_accept && idx == LAST_IDX) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // FSM output logic: next values of the registered outputs and byte index.
  always_comb begin
    tx_start_next   = 1'b0;
    frame_done_next = 1'b0;
    tx_data_next    = tx_data;
    busy_next       = busy;
    idx_next        = idx;
    case (state)
      IDLE: begin
        if (frame_start) begin
          tx_start_next = 1'b1;
          tx_data_next  = 8'hFF;
          busy_next     = 1'b1;
          idx_next      = 4'd0;
        end
      end
      WAIT_DONE: begin
        if (byte_accept) begin
          if (idx == LAST_IDX) begin
            busy_next       = 1'b0;
            frame_done_next = 1'b1;
          end else begin
            idx_next      = idx_inc;
            tx_data_next  = frame_byte(snap, idx_inc);
            tx_start_next = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Output registers: no combinational path from any input to any output.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      idx        <= 4'd0;
    end else begin
      tx_start   <= tx_start_next;
      tx_data    <= tx_data_next;
      busy       <= busy_next;
      frame_done <= frame_done_next;
      idx        <= idx_next;
    end
  end

endmodule
